// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM state encoding and alignment helper for the memory access unit.
package mem_access_unit_pkg;

  // Access size codes; 2'b11 is treated as a word everywhere.
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Halves need an even address, words (and 2'b11) need a 4-byte aligned address.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    unique case (size)
      MEM_B:   ok = 1'b1;
      MEM_H:   ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        load_signed_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Decode size into byte enables, replicated store data and extended load data.
  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = 32'h0;
    load_data_o = 32'h0;
    unique case (size_i)
      MEM_B: begin
        be_o        = 4'b0001 << lane_i;
        wdata_o     = {4{wdata_i[7:0]}};
        load_data_o = {{24{load_signed_i & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{wdata_i[15:0]}};
        load_data_o = {{16{load_signed_i & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: turns load/store requests into a req/ack bus transaction with
// alignment checking, ack timeout and a one-cycle completion pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        signed_q, signed_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic        req_in;
  logic [1:0]  al_size;
  logic [1:0]  al_lane;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign req_in = mem_read | mem_write;

  // In IDLE the aligner steers the incoming request; in BUSY it extracts the captured lane.
  assign al_size   = (state_q == ST_IDLE) ? size        : size_q;
  assign al_lane   = (state_q == ST_IDLE) ? addr[1:0]   : lane_q;
  assign al_signed = (state_q == ST_IDLE) ? load_signed : signed_q;

  mem_lane_align u_lane_align (
    .size_i        (al_size),
    .lane_i        (al_lane),
    .wdata_i       (wdata),
    .rdata_i       (bus_rdata),
    .load_signed_i (al_signed),
    .be_o          (al_be),
    .wdata_o       (al_wdata),
    .load_data_o   (al_load)
  );

  // Next-state logic: FSM, bus register loading and timeout counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    lane_d   = lane_q;
    signed_d = signed_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          if (!is_aligned(size, addr[1:0])) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d  = ST_BUSY;
            req_d    = 1'b1;
            we_d     = mem_write;
            addr_d   = {addr[31:2], 2'b00};
            be_d     = al_be;
            wdata_d  = al_wdata;
            size_d   = size;
            lane_d   = addr[1:0];
            signed_d = load_signed;
            cnt_d    = 16'h0;
          end
        end
      end
      ST_BUSY: begin
        if (bus_ack || (cnt_q == TimeoutLast)) begin
          // Ack wins over a coincident timeout.
          state_d = ST_RESP;
          done_d  = 1'b1;
          to_d    = ~bus_ack;
          rdata_d = (bus_ack && !we_q) ? al_load : 32'h0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          be_d    = 4'b0000;
          wdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any outstanding transaction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'h0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      size_q   <= MEM_B;
      lane_q   <= 2'b00;
      signed_q <= 1'b0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      signed_q <= signed_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
    end
  end

  // Stall is gated by reset so it drops the instant reset asserts.
  assign stall = rst_n & (((state_q == ST_IDLE) & req_in) | (state_q == ST_BUSY));

  assign rdata        = rdata_q;
  assign done         = done_q;
  assign err_misalign = mis_q;
  assign err_timeout  = to_q;
  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed plan items plus random accesses.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        mem_read, mem_write, load_signed;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, done, err_misalign, err_timeout;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .load_signed  (load_signed),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .done         (done),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        to;
    int          req_cycles;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        skip = 1'b0;
  int          rsp_lat = 1;
  logic [31:0] rsp_data = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what the access should look like on the bus and at completion.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] w, input int lat,
                                 input logic [31:0] rv);
    exp_t        e;
    int          s;
    logic [31:0] v;
    s       = (sz == 2'd3) ? 2 : int'(sz);
    e.we    = wr;
    e.addr  = a & ~32'h3;
    if (s == 0) begin
      e.be    = 32'(1) << a[1:0];
      e.wdata = (w & 32'hFF) * 32'h0101_0101;
      v       = (rv >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      e.mis   = 1'b0;
    end else if (s == 1) begin
      e.be    = 32'(3) << (2 * a[1]);
      e.wdata = (w & 32'hFFFF) * 32'h0001_0001;
      v       = (rv >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      e.mis   = (a % 2) != 0;
    end else begin
      e.be    = 32'hF;
      e.wdata = w;
      v       = rv;
      e.mis   = (a % 4) != 0;
    end
    e.to         = !e.mis && (lat > TO);
    e.req_cycles = e.mis ? 0 : ((lat > TO) ? TO : lat);
    e.rdata      = (e.mis || e.to || wr) ? 32'h0 : v;
    e.done_cyc   = 0;
    return e;
  endfunction

  // Drive one access and hold it until the completion pulse.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] w, input int lat,
                        input logic [31:0] rv);
    exp_t e;
    logic got;
    e = model(wr, sz, sg, a, w, lat, rv);
    @(negedge clk);
    rsp_lat    = lat;
    rsp_data   = rv;
    e.done_cyc = cyc + 1 + e.req_cycles;
    q.push_back(e);
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    load_signed = sg;
    addr        = a;
    wdata       = w;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_wait: no done within 20 cycles, want done");
    end
    @(posedge clk);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Memory responder: ack after rsp_lat cycles of bus_req, spurious acks while idle.
  initial begin : responder
    int cnt;
    cnt       = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        cnt++;
        bus_ack   = (cnt == rsp_lat);
        bus_rdata = (cnt == rsp_lat) ? rsp_data : $urandom;
      end else begin
        cnt       = 0;
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: checks bus fields while bus_req is high and pops one item per done pulse.
  initial begin : monitor
    exp_t e;
    int   req_cnt;
    req_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (skip || !rst_n) begin
        req_cnt = 0;
      end else begin
        if (bus_req) begin
          if (q.size() == 0 || q[0].mis) begin
            total++;
            bad++;
            $display("FAIL unexpected_bus_req: bus_req=1 want 0 (cycle %0d)", cyc);
          end else begin
            chk("bus_we", 32'(bus_we), 32'(q[0].we));
            chk("bus_addr", bus_addr, q[0].addr);
            chk("bus_be", 32'(bus_be), q[0].be);
            if (q[0].we) chk("bus_wdata", bus_wdata, q[0].wdata);
            chk("stall_busy", 32'(stall), 32'h1);
          end
          req_cnt++;
        end
        if (done) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: done=1 want 0 (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("err_misalign", 32'(err_misalign), 32'(e.mis));
            chk("err_timeout", 32'(err_timeout), 32'(e.to));
            chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("stall_resp", 32'(stall), 32'h0);
          end
          req_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    logic        rd, wr;
    logic [31:0] a;
    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    size        = 2'b00;
    load_signed = 1'b0;
    addr        = 32'h0;
    wdata       = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_errs", 32'({err_misalign, err_timeout}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 3, 32'h0);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1, 32'h8012_3456);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 2, 32'h8012_3456);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 1, 32'hBEEF_1234);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h300, 32'h0000_A5A5, 2, 32'h0);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h401, 32'h1234_5678, 1, 32'h0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 10, 32'h1111_2222);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h604, 32'h0, TO, 32'h3333_4444);

    // Reset in the middle of a transaction.
    @(negedge clk);
    skip        = 1'b1;
    rsp_lat     = 100;
    mem_read    = 1'b1;
    size        = 2'b10;
    addr        = 32'h500;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_pre_bus_req", 32'(bus_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_bus_req", 32'(bus_req), 32'h0);
    skip = 1'b0;
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h502, 32'h0, 2, 32'h9ABC_0001);

    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(1, TO + 2), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
